// File: rtl/hash_uram_pkg.sv
// Shared constants, FSM encoding and tracker slot layout for the URAM
// read-modify-write scheduler.
package hash_uram_pkg;
  localparam int NUM_MUL     = 4;
  localparam int INDEX_WIDTH = 12;
  localparam int DATA_WIDTH  = 64;
  localparam int RD_LATENCY  = 2;
  localparam int LANES_W     = NUM_MUL * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic                   valid;
    logic [INDEX_WIDTH-1:0] index;
    logic [NUM_MUL-1:0]     mask;
    logic [LANES_W-1:0]     delta;
  } slot_t;

  // An in-flight update blocks a request only if it touches the same row
  // and at least one of the same banks.
  function automatic logic slot_hit(input logic                   valid,
                                    input logic [INDEX_WIDTH-1:0] index,
                                    input logic [NUM_MUL-1:0]     mask,
                                    input logic [INDEX_WIDTH-1:0] chk_index,
                                    input logic [NUM_MUL-1:0]     chk_mask);
    return valid && (index == chk_index) && ((mask & chk_mask) != '0);
  endfunction
endpackage

// File: rtl/uram_inflight_tracker.sv
// Shift register of in-flight updates: RD_LATENCY full slots feeding the XOR
// datapath plus one header-only slot covering the write-commit cycle.
module uram_inflight_tracker
  import hash_uram_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  slot_t                  push_slot_i,
  input  logic [INDEX_WIDTH-1:0] chk_index_i,
  input  logic [NUM_MUL-1:0]     chk_mask_i,
  output logic                   hazard,
  output logic                   empty,
  output slot_t                  wr_slot_o
);
  slot_t [RD_LATENCY-1:0]  slot_q;
  logic                    last_valid_q;
  logic [INDEX_WIDTH-1:0]  last_index_q;
  logic [NUM_MUL-1:0]      last_mask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q       <= '0;
      last_valid_q <= 1'b0;
      last_index_q <= '0;
      last_mask_q  <= '0;
    end else begin
      slot_q[0] <= push_slot_i;
      for (int i = 1; i < RD_LATENCY; i++) begin
        slot_q[i] <= slot_q[i-1];
      end
      last_valid_q <= slot_q[RD_LATENCY-1].valid;
      last_index_q <= slot_q[RD_LATENCY-1].index;
      last_mask_q  <= slot_q[RD_LATENCY-1].mask;
    end
  end

  always_comb begin
    hazard = slot_hit(last_valid_q, last_index_q, last_mask_q, chk_index_i, chk_mask_i);
    empty  = !last_valid_q;
    for (int i = 0; i < RD_LATENCY; i++) begin
      if (slot_q[i].valid) begin
        empty = 1'b0;
      end
      if (slot_hit(slot_q[i].valid, slot_q[i].index, slot_q[i].mask, chk_index_i, chk_mask_i)) begin
        hazard = 1'b1;
      end
    end
  end

  // The oldest full slot is the one whose read data arrives this cycle.
  assign wr_slot_o = slot_q[RD_LATENCY-1];
endmodule

// File: rtl/uram_update_scheduler.sv
// XOR read-modify-write scheduler for the banked URAM hash table, with
// hazard stalling (banks have no forwarding) and full-table zero fill.
module uram_update_scheduler
  import hash_uram_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [INDEX_WIDTH-1:0] req_index,
  input  logic [NUM_MUL-1:0]     req_mask,
  input  logic [LANES_W-1:0]     req_delta,
  input  logic                   clear_req,
  output logic [INDEX_WIDTH-1:0] rd_index,
  input  logic [LANES_W-1:0]     rd_out_update,
  output logic                   write_reg_11_valid,
  output logic [INDEX_WIDTH-1:0] write_reg_11_index,
  output logic [LANES_W-1:0]     write_reg_11_xor,
  output logic [NUM_MUL-1:0]     arbiter_result,
  output logic                   init_busy,
  output logic [15:0]            stall_cnt
);
  state_e                 state_q;
  logic [INDEX_WIDTH:0]   clr_cnt_q;
  logic                   wr_valid_q;
  logic [INDEX_WIDTH-1:0] wr_index_q;
  logic [LANES_W-1:0]     wr_xor_q;
  logic [LANES_W-1:0]     wr_xor_d;
  logic [NUM_MUL-1:0]     wr_arb_q;
  logic [15:0]            stall_cnt_q;
  logic                   hazard;
  logic                   trk_empty;
  logic                   accept;
  slot_t                  push_slot;
  slot_t                  wr_slot;

  // Handshake: a request transfers on any edge where req_valid && req_ready;
  // req_ready depends only on state and the hazard compare, never on req_valid.
  assign req_ready = (state_q == ST_RUN) && !hazard;
  assign accept    = req_valid && req_ready;
  assign rd_index  = req_index;
  assign init_busy = (state_q != ST_RUN);

  always_comb begin
    push_slot       = '0;
    push_slot.valid = accept;
    push_slot.index = req_index;
    push_slot.mask  = req_mask;
    push_slot.delta = req_delta;
  end

  uram_inflight_tracker u_tracker (
    .clk         (clk),
    .reset       (reset),
    .push_slot_i (push_slot),
    .chk_index_i (req_index),
    .chk_mask_i  (req_mask),
    .hazard      (hazard),
    .empty       (trk_empty),
    .wr_slot_o   (wr_slot)
  );

  always_comb begin
    wr_xor_d = rd_out_update;
    for (int i = 0; i < NUM_MUL; i++) begin
      if (wr_slot.mask[i]) begin
        wr_xor_d[DATA_WIDTH*i +: DATA_WIDTH] = rd_out_update[DATA_WIDTH*i +: DATA_WIDTH]
                                             ^ wr_slot.delta[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      clr_cnt_q   <= '0;
      wr_valid_q  <= 1'b0;
      wr_index_q  <= '0;
      wr_xor_q    <= '0;
      wr_arb_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if ((state_q == ST_RUN) && req_valid && hazard && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      case (state_q)
        ST_INIT: begin
          // The extra top counter bit buys one idle cycle after the last fill write.
          if (clr_cnt_q[INDEX_WIDTH]) begin
            state_q    <= ST_RUN;
            wr_valid_q <= 1'b0;
            wr_arb_q   <= '0;
          end else begin
            wr_valid_q <= 1'b1;
            wr_index_q <= clr_cnt_q[INDEX_WIDTH-1:0];
            wr_xor_q   <= '0;
            wr_arb_q   <= '1;
            clr_cnt_q  <= clr_cnt_q + (INDEX_WIDTH+1)'(1);
          end
        end
        default: begin
          if (wr_slot.valid && (wr_slot.mask != '0)) begin
            wr_valid_q <= 1'b1;
            wr_index_q <= wr_slot.index;
            wr_xor_q   <= wr_xor_d;
            wr_arb_q   <= wr_slot.mask;
          end else begin
            wr_valid_q <= 1'b0;
            wr_arb_q   <= '0;
          end
          if ((state_q == ST_RUN) && clear_req) begin
            state_q <= ST_DRAIN;
          end else if ((state_q == ST_DRAIN) && trk_empty) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
          end
        end
      endcase
    end
  end

  assign write_reg_11_valid = wr_valid_q;
  assign write_reg_11_index = wr_index_q;
  assign write_reg_11_xor   = wr_xor_q;
  assign arbiter_result     = wr_arb_q;
  assign stall_cnt          = stall_cnt_q;
endmodule

// File: tb/tb_uram_update_scheduler.sv
// Bench for uram_update_scheduler: bank RAM model with 2-edge read latency,
// reference table plus expected-write queue, directed and random traffic.
module tb_uram_update_scheduler;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid;
  logic         req_ready;
  logic [11:0]  req_index;
  logic [3:0]   req_mask;
  logic [255:0] req_delta;
  logic         clear_req;
  logic [11:0]  rd_index;
  logic [255:0] rd_out_update;
  logic         write_reg_11_valid;
  logic [11:0]  write_reg_11_index;
  logic [255:0] write_reg_11_xor;
  logic [3:0]   arbiter_result;
  logic         init_busy;
  logic [15:0]  stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Entry layout: {index[527:516], mask[515:512], compare_mask[511:256], data[255:0]}
  logic [527:0] exp_q[$];
  logic [527:0] mon_e;
  logic [255:0] ref_mem  [4096];
  logic [255:0] bank_mem [4096];
  logic [11:0]  ra1, ra2;

  uram_update_scheduler dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_index          (req_index),
    .req_mask           (req_mask),
    .req_delta          (req_delta),
    .clear_req          (clear_req),
    .rd_index           (rd_index),
    .rd_out_update      (rd_out_update),
    .write_reg_11_valid (write_reg_11_valid),
    .write_reg_11_index (write_reg_11_index),
    .write_reg_11_xor   (write_reg_11_xor),
    .arbiter_result     (arbiter_result),
    .init_busy          (init_busy),
    .stall_cnt          (stall_cnt)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bank RAM model ----------------
  always @(posedge clk) begin
    ra1 <= rd_index;
    ra2 <= ra1;
    if (write_reg_11_valid) begin
      for (int i = 0; i < 4; i++) begin
        if (arbiter_result[i]) bank_mem[write_reg_11_index][64*i +: 64] <= write_reg_11_xor[64*i +: 64];
      end
    end
  end
  assign rd_out_update = bank_mem[ra2];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [271:0] got, input logic [271:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (write_reg_11_valid) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 272'(write_reg_11_valid), 272'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("wr", {write_reg_11_index, arbiter_result, write_reg_11_xor & mon_e[511:256]},
                      {mon_e[527:516], mon_e[515:512], mon_e[255:0] & mon_e[511:256]});
        end
      end else begin
        check("arb_idle", 272'(arbiter_result), 272'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_init();
    for (int k = 0; k < 4096; k++) begin
      ref_mem[k] = '0;
      exp_q.push_back({12'(k), 4'hF, {256{1'b1}}, 256'h0});
    end
  endtask

  task automatic send(input logic [11:0] idx, input logic [3:0] m, input logic [255:0] d,
                      input bit full, output int stalls);
    logic [255:0] nv;
    logic [255:0] cmp;
    stalls = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_index = idx;
    req_mask  = m;
    req_delta = d;
    #1;
    while (!req_ready && stalls < 40) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!req_ready) begin
      check("send_timeout", 272'(req_ready), 272'(1));
      req_valid = 1'b0;
      return;
    end
    nv  = ref_mem[idx];
    cmp = '0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) nv[64*i +: 64] = nv[64*i +: 64] ^ d[64*i +: 64];
      if (m[i] || full) cmp[64*i +: 64] = '1;
    end
    ref_mem[idx] = nv;
    if (m != 4'h0) exp_q.push_back({idx, m, cmp, nv});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Counts negedges until req_ready; pulses clear_req at negedges clr_a / clr_b.
  task automatic wait_ready(input int exp_n, input int clr_a, input int clr_b, input string tag);
    int n = 0;
    logic       prev_v = 1'b0;
    logic [11:0] prev_idx = '0;
    while (n < 6000) begin
      @(negedge clk);
      n++;
      clear_req = (n == clr_a) || (n == clr_b);
      if (req_ready) break;
      prev_v   = write_reg_11_valid;
      prev_idx = write_reg_11_index;
    end
    clear_req = 1'b0;
    check({tag, "_ready_cycle"}, 272'(n), 272'(exp_n));
    check({tag, "_last_init_wr"}, 272'({prev_v, prev_idx}), 272'({1'b1, 12'hFFF}));
  endtask

  task automatic wait_write(input logic [11:0] idx, input int exp_n, input string tag);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (write_reg_11_valid && write_reg_11_index == idx) seen = 1'b1;
    end
    check(tag, 272'(n), 272'(exp_n));
  endtask

  function automatic logic [255:0] rand_delta();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int st;
    int exp_stall;
    logic [255:0] d1, d2;
    req_valid = 1'b0;
    req_index = '0;
    req_mask  = '0;
    req_delta = '0;
    clear_req = 1'b0;
    exp_stall = 0;

    repeat (3) @(negedge clk);
    check("rst_ready",    272'(req_ready), 272'(0));
    check("rst_busy",     272'(init_busy), 272'(1));
    check("rst_wr_valid", 272'(write_reg_11_valid), 272'(0));
    check("rst_wr_index", 272'(write_reg_11_index), 272'(0));
    check("rst_wr_xor",   272'(write_reg_11_xor), 272'(0));
    check("rst_arb",      272'(arbiter_result), 272'(0));
    check("rst_stall",    272'(stall_cnt), 272'(0));
    #2 reset = 1'b0;
    push_init();
    wait_ready(4097, 0, 0, "init");

    // single-lane update onto a zeroed row
    send(12'd5, 4'b0001, 256'hA5, 1'b1, st);
    check("idx5_stall", 272'(st), 272'(0));
    wait_write(12'd5, 3, "idx5_latency");
    check("idx5_arb",         272'(arbiter_result), 272'(4'b0001));
    check("idx5_lane0",       272'(write_reg_11_xor[63:0]), 272'(64'hA5));
    check("idx5_other_lanes", 272'(write_reg_11_xor[255:64]), 272'(0));

    // overlapping masks on the same row: second request waits for the commit
    d1 = {64'h1111_2222_3333_4444, 64'h0F0F_0F0F_0F0F_0F0F, 64'hDEAD_BEEF_0000_0001, 64'h8000_0000_0000_0003};
    d2 = {64'h0, 64'h0, 64'h1234_5678_9ABC_DEF0, 64'h0};
    send(12'd7, 4'hF, d1, 1'b1, st);
    check("idx7_first_stall", 272'(st), 272'(0));
    send(12'd7, 4'b0010, d2, 1'b1, st);
    check("idx7_stall_cycles", 272'(st), 272'(3));
    check("idx7_stall_cnt",    272'(stall_cnt), 272'(3));
    exp_stall = 3;
    repeat (5) @(negedge clk);
    check("idx7_lane1_final", 272'(bank_mem[7][127:64]), 272'(d1[127:64] ^ d2[127:64]));

    // disjoint masks on the same row: no stall
    send(12'd9, 4'b0001, rand_delta(), 1'b0, st);
    check("idx9_a_stall", 272'(st), 272'(0));
    send(12'd9, 4'b0010, rand_delta(), 1'b0, st);
    check("idx9_b_stall", 272'(st), 272'(0));
    check("idx9_stall_cnt", 272'(stall_cnt), 272'(exp_stall));

    // random traffic on a few hot rows, including empty masks
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      send(12'(40 + $urandom_range(0, 3)), 4'($urandom_range(0, 15)), rand_delta(), 1'b0, st);
      exp_stall += st;
    end
    check("random_stall_cnt", 272'(stall_cnt), 272'(exp_stall));

    // clear with two updates in flight; further clear pulses in DRAIN/INIT ignored
    send(12'd20, 4'hF, rand_delta(), 1'b0, st);
    send(12'd21, 4'b0011, rand_delta(), 1'b0, st);
    @(negedge clk);
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    check("drain_busy",  272'(init_busy), 272'(1));
    check("drain_ready", 272'(req_ready), 272'(0));
    push_init();
    wait_ready(4101, 2, 200, "clear");

    // reset with two updates in flight
    send(12'd30, 4'hF, rand_delta(), 1'b0, st);
    send(12'd31, 4'hF, rand_delta(), 1'b0, st);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_wr_valid", 272'(write_reg_11_valid), 272'(0));
    check("mid_rst_wr_index", 272'(write_reg_11_index), 272'(0));
    check("mid_rst_wr_xor",   272'(write_reg_11_xor), 272'(0));
    check("mid_rst_arb",      272'(arbiter_result), 272'(0));
    check("mid_rst_ready",    272'(req_ready), 272'(0));
    check("mid_rst_busy",     272'(init_busy), 272'(1));
    check("mid_rst_stall",    272'(stall_cnt), 272'(0));
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    push_init();
    wait_ready(4097, 0, 0, "reinit");

    send(12'd30, 4'b0100, rand_delta(), 1'b1, st);
    check("post_rst_stall", 272'(st), 272'(0));
    repeat (8) @(negedge clk);
    check("exp_q_drained", 272'(exp_q.size()), 272'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uram_update_scheduler.md
# uram_update_scheduler

Read-modify-write scheduler for the banked URAM hash table (NUM_MUL banks, one index space, no data-forwarding unit). It accepts XOR-update requests, issues the bank read, XORs the returned words with the request delta and drives the bank write port (`write_reg_11_*`, `arbiter_result`). Because the banks have no forwarding path, it stalls any request whose index collides with an in-flight update. After reset or on request it zero-fills the whole table.

## Interface
- `NUM_MUL`, 4, number of banks / lanes
- `INDEX_WIDTH`, 12, table address width (depth 2^INDEX_WIDTH)
- `DATA_WIDTH`, 64, word width per bank
- `RD_LATENCY`, 2, bank read latency in edges (address sampled at edge E0, data sampled by this block at edge E_RD_LATENCY)

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  update request valid
- `req_ready`  out  1  request accepted when `req_valid && req_ready` at an edge
- `req_index`  in  INDEX_WIDTH  table index
- `req_mask`  in  NUM_MUL  banks to update
- `req_delta`  in  NUM_MUL*DATA_WIDTH  XOR delta; lane i at [DATA_WIDTH*i +: DATA_WIDTH]
- `clear_req`  in  1  one-cycle pulse requesting a full table clear
- `rd_index`  out  INDEX_WIDTH  bank read address
- `rd_out_update`  in  NUM_MUL*DATA_WIDTH  bank read data
- `write_reg_11_valid`  out  1  bank write-port enable
- `write_reg_11_index`  out  INDEX_WIDTH  write address
- `write_reg_11_xor`  out  NUM_MUL*DATA_WIDTH  write data
- `arbiter_result`  out  NUM_MUL  per-bank write enable
- `init_busy`  out  1  high while in DRAIN or INIT
- `stall_cnt`  out  16  saturating count of hazard-stalled cycles

## Operation
- FSM: INIT, RUN, DRAIN. Reset puts the FSM in INIT with the clear counter at 0.
- INIT writes one index per cycle: `write_reg_11_valid`=1, `arbiter_result`=all ones, `write_reg_11_xor`=0, index 0 up to 2^INDEX_WIDTH-1. After the last index, the FSM goes to RUN. `req_ready`=0 in INIT.
- RUN: `req_ready`=1 unless a hazard is present. A hazard exists when any valid tracker slot has the same index as `req_index` and its mask ANDed with `req_mask` is non-zero.
- Tracker: a shift register of RD_LATENCY+1 slots {valid, index, mask, delta}. An accepted request enters slot 0. Slot RD_LATENCY+... retires the edge after its write commits.
- The request is accepted at edge E0. At edge E_RD_LATENCY the block samples `rd_out_update` and registers the write:
  - lanes in the mask get `rd ^ delta`;
  - other lanes get `rd` unchanged.
  The write outputs are asserted during the cycle after E_RD_LATENCY, and the RAM commits the write at E_RD_LATENCY+1.
- `req_mask`=0: the request is accepted and occupies a tracker slot. No write is issued (`write_reg_11_valid`=0).
- `clear_req` in RUN: go to DRAIN and force `req_ready`=0. When the tracker is empty, go to INIT with the counter at 0. `clear_req` in INIT or DRAIN is ignored.
- When no write is issued, `write_reg_11_valid`=0 and `arbiter_result`=0.
- `stall_cnt` increments on each RUN cycle with `req_valid && !req_ready` caused by a hazard. It saturates at 16'hFFFF and is cleared only by reset.
- Reset mid-operation discards all in-flight updates and restarts INIT.

## Timing
- Reset values: `req_ready`=0, `write_reg_11_valid`=0, `write_reg_11_index`=0, `write_reg_11_xor`=0, `arbiter_result`=0, `init_busy`=1, `stall_cnt`=0, tracker all invalid.
- Write outputs are registered. `rd_index`=`req_index` combinationally. `req_ready` is combinational from the state and the hazard compare and never depends on `req_valid`.
- INIT write k appears in the cycle after edge k+1 following reset release. `req_ready` may first be 1 in the cycle after the last INIT write.
- Request-to-write-commit latency is RD_LATENCY+1 edges. Throughput is one update per cycle when there are no hazards.
- Back-to-back same index with overlapping masks: the second request is stalled for RD_LATENCY+1 cycles, then reads the committed value.
- Same index with disjoint masks: no stall.

## Structure
- Package `hash_uram_pkg`: default NUM_MUL/INDEX_WIDTH/DATA_WIDTH/RD_LATENCY, FSM state enum, and the tracker slot struct.
- Sub-module `uram_inflight_tracker`: the slot shift register, the hazard compare (`hazard` output) and the `empty` flag. The top level owns the FSM, the XOR datapath and the counters.

## Test plan
- Reset release, then 4096 cycles: write indexes 0..4095 with mask 4'hF and data 0. `req_ready` rises in the cycle after index 4095.
- Request idx 5, mask 4'b0001, lane0 delta 64'hA5; bench RAM returns 0: write idx 5, `arbiter_result`=4'b0001, lane0 = 64'hA5, 3 edges after accept.
- Requests idx 7 mask 4'hF, then idx 7 mask 4'b0010 on consecutive cycles: `req_ready`=0 for 3 cycles, `stall_cnt`=3, and the final lane1 value equals delta1 ^ delta2.
- Requests idx 9 mask 4'b0001, then idx 9 mask 4'b0010 back-to-back: both are accepted with no stall.
- `clear_req` with 2 updates in flight: both writes complete, `init_busy`=1, then a full INIT sweep, then RUN.
- Reset asserted mid-pipeline: all outputs are zero immediately, no stale write follows, and INIT restarts at index 0.
